// File: rtl/lfsr_checker.sv
// lfsr_checker: self-synchronising serial PRBS checker with lock detect and saturating BER counters
module lfsr_checker #(
  parameter int WIDTH = 4,
  parameter logic [WIDTH-1:0] TAPS = 4'b1100,
  parameter int LOCK_CNT = 8,
  parameter int LOSS_CNT = 4,
  parameter int ERR_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             din_valid,
  input  logic             din,
  input  logic             clr_cnt,
  output logic             locked,
  output logic             err_pulse,
  output logic [ERR_W-1:0] err_count,
  output logic [ERR_W-1:0] bit_count
);
  localparam int SW = $clog2(WIDTH + 1);
  localparam int MW = $clog2(LOCK_CNT + 1);
  localparam int LW = $clog2(LOSS_CNT + 1);
  typedef enum logic [1:0] {SEED, ACQ, LOCK} state_t;
  state_t state;
  logic [WIDTH-1:0] sh;
  logic [SW-1:0] seed_cnt;
  logic [MW-1:0] match_cnt;
  logic [LW-1:0] miss_cnt;
  logic exp_bit, beat, err;
  logic [ERR_W-1:0] err_base, bit_base, err_next, bit_next;
  // prediction, locked-beat events and saturating counter next values
  always_comb begin
    exp_bit = ^(sh & TAPS);
    beat = din_valid && state == LOCK;
    err = beat && din != exp_bit;
    err_base = clr_cnt ? '0 : err_count;
    bit_base = clr_cnt ? '0 : bit_count;
    err_next = err_base + ERR_W'(err && ~&err_base);
    bit_next = bit_base + ERR_W'(beat && ~&bit_base);
  end
  // seed / acquire / flywheel-lock state machine
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= SEED;
      sh <= '0;
      seed_cnt <= '0;
      match_cnt <= '0;
      miss_cnt <= '0;
      locked <= 1'b0;
      err_pulse <= 1'b0;
    end else begin
      err_pulse <= err;
      if (din_valid)
        case (state)
          SEED: begin
            sh <= {sh[WIDTH-2:0], din};
            seed_cnt <= seed_cnt + SW'(1);
            if (seed_cnt == SW'(WIDTH - 1)) begin
              state <= ACQ;
              seed_cnt <= '0;
              match_cnt <= '0;
            end
          end
          ACQ: begin
            sh <= {sh[WIDTH-2:0], din};
            if (din == exp_bit && sh != '0) begin
              if (match_cnt == MW'(LOCK_CNT - 1)) begin
                state <= LOCK;
                locked <= 1'b1;
                match_cnt <= '0;
                miss_cnt <= '0;
              end else
                match_cnt <= match_cnt + MW'(1);
            end else
              match_cnt <= '0;
          end
          LOCK: begin
            sh <= {sh[WIDTH-2:0], exp_bit};
            miss_cnt <= err ? miss_cnt + LW'(1) : '0;
            if (err && miss_cnt == LW'(LOSS_CNT - 1)) begin
              state <= SEED;
              locked <= 1'b0;
              sh <= '0;
              seed_cnt <= '0;
              miss_cnt <= '0;
            end
          end
          default: state <= SEED;
        endcase
    end
  end
  // error and checked-bit counters
  always_ff @(posedge clk) begin
    if (rst) begin
      err_count <= '0;
      bit_count <= '0;
    end else begin
      err_count <= err_next;
      bit_count <= bit_next;
    end
  end
endmodule

// File: tb/tb_lfsr_checker.sv
// tb_lfsr_checker: randomized scoreboard bench for lfsr_checker (16-bit and 4-bit counter variants)
module tb_lfsr_checker;
  logic clk = 1'b0;
  logic rst = 1'b1, din_valid = 1'b0, din = 1'b0, clr_cnt = 1'b0;
  logic locked, err_pulse, locked4, err_pulse4;
  logic [15:0] err_count, bit_count;
  logic [3:0] err_count4, bit_count4;
  int vectors = 0, miscompares = 0;
  typedef struct {bit lk; bit pl; int e16; int b16; int e4; int b4;} exp_t;
  exp_t sbq[$];
  bit hist[$];
  int mode, run, miss, e16, b16, e4, b4;
  bit mlk, mpl;
  logic [3:0] w;
  always #5 clk = ~clk;
  lfsr_checker dut (.clk(clk), .rst(rst), .din_valid(din_valid), .din(din), .clr_cnt(clr_cnt),
    .locked(locked), .err_pulse(err_pulse), .err_count(err_count), .bit_count(bit_count));
  lfsr_checker #(.ERR_W(4)) dut4 (.clk(clk), .rst(rst), .din_valid(din_valid), .din(din), .clr_cnt(clr_cnt),
    .locked(locked4), .err_pulse(err_pulse4), .err_count(err_count4), .bit_count(bit_count4));
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    vectors++;
    if (act !== expv) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, expv, $time);
    end
  endtask
  function automatic int sat(input int v, input int mx);
    return v < mx ? v + 1 : v;
  endfunction
  // reference: bit history window, x^4+x^3+1 prediction b[n]=b[n-4]^b[n-3]
  task automatic model(input bit r, input bit v, input bit d, input bit c);
    bit lk, e, p, nz;
    lk = 0;
    e = 0;
    if (r) begin
      mode = 0; hist.delete(); run = 0; miss = 0; mlk = 0; mpl = 0;
      e16 = 0; b16 = 0; e4 = 0; b4 = 0;
      return;
    end
    if (v) begin
      if (mode == 0) begin
        hist.push_back(d);
        if (hist.size() == 4) begin mode = 1; run = 0; end
      end else begin
        p = hist[0] ^ hist[1];
        nz = hist[0] | hist[1] | hist[2] | hist[3];
        if (mode == 1) begin
          run = (d == p && nz) ? run + 1 : 0;
          hist.push_back(d);
          if (run == 8) begin mode = 2; miss = 0; end
        end else begin
          lk = 1;
          e = d != p;
          hist.push_back(p);
          miss = e ? miss + 1 : 0;
          if (miss == 4) begin mode = 0; hist.delete(); miss = 0; end
        end
        if (hist.size() > 4) void'(hist.pop_front());
      end
    end
    mpl = e;
    mlk = mode == 2;
    if (c) begin e16 = 0; b16 = 0; e4 = 0; b4 = 0; end
    if (lk) begin b16 = sat(b16, 65535); b4 = sat(b4, 15); end
    if (e) begin e16 = sat(e16, 65535); e4 = sat(e4, 15); end
  endtask
  task automatic drive(input bit r, input bit v, input bit d, input bit c);
    exp_t x;
    @(negedge clk);
    rst = r; din_valid = v; din = d; clr_cnt = c;
    model(r, v, d, c);
    x.lk = mlk; x.pl = mpl; x.e16 = e16; x.b16 = b16; x.e4 = e4; x.b4 = b4;
    sbq.push_back(x);
  endtask
  task automatic nb(output bit b);
    b = w[3];
    w = {w[2:0], w[3] ^ w[2]};
  endtask
  task automatic good(input int n);
    bit b;
    repeat (n) begin nb(b); drive(0, 1, b, 0); end
  endtask
  task automatic bad(input int n);
    bit b;
    repeat (n) begin nb(b); drive(0, 1, ~b, 0); end
  endtask
  task automatic settle;
    @(posedge clk);
    #2;
  endtask
  task automatic do_reset;
    drive(1, 0, 0, 0);
    drive(0, 0, 0, 0);
    w = 4'b0001;
  endtask
  // monitor: compare every post-edge output against the queued expectation
  initial begin
    exp_t x;
    forever begin
      @(posedge clk);
      #1;
      if (sbq.size() > 0) begin
        x = sbq.pop_front();
        chk("locked", 32'(locked), 32'(x.lk));
        chk("err_pulse", 32'(err_pulse), 32'(x.pl));
        chk("err_count", 32'(err_count), 32'(x.e16));
        chk("bit_count", 32'(bit_count), 32'(x.b16));
        chk("locked4", 32'(locked4), 32'(x.lk));
        chk("err_count4", 32'(err_count4), 32'(x.e4));
        chk("bit_count4", 32'(bit_count4), 32'(x.b4));
      end
    end
  end
  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end
  initial begin
    bit b;
    do_reset();
    settle();
    chk("reset_locked", 32'(locked), 0);
    chk("reset_err", 32'(err_count), 0);
    good(11);
    settle();
    chk("t1_not_locked_11", 32'(locked), 0);
    good(1);
    settle();
    chk("t1_locked_12", 32'(locked), 1);
    good(100);
    settle();
    chk("t1_bit_count", 32'(bit_count), 100);
    chk("t1_err_count", 32'(err_count), 0);
    bad(1);
    settle();
    chk("t2_err_pulse", 32'(err_pulse), 1);
    chk("t2_err_count", 32'(err_count), 1);
    good(20);
    settle();
    chk("t2_flywheel_err", 32'(err_count), 1);
    chk("t2_locked", 32'(locked), 1);
    bad(3);
    settle();
    chk("t3_still_locked", 32'(locked), 1);
    bad(1);
    settle();
    chk("t3_lost", 32'(locked), 0);
    good(11);
    settle();
    chk("t3_not_relocked", 32'(locked), 0);
    good(1);
    settle();
    chk("t3_relocked", 32'(locked), 1);
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 3) != 0) begin
        nb(b);
        drive(0, 1, b ^ ($urandom_range(0, 19) == 0), $urandom_range(0, 60) == 0);
      end else
        drive(0, 0, 1'($urandom), 0);
    end
    do_reset();
    repeat (200) drive(0, 1, 0, 0);
    settle();
    chk("t4_dead_line", 32'(locked), 0);
    do_reset();
    repeat (11) begin nb(b); drive(0, 1, b, 0); drive(0, 0, ~b, 0); end
    settle();
    chk("t5_not_locked_11", 32'(locked), 0);
    nb(b);
    drive(0, 1, b, 0);
    settle();
    chk("t5_locked_12", 32'(locked), 1);
    drive(0, 0, 0, 0);
    good(5);
    drive(1, 1, 0, 0);
    settle();
    chk("t5_rst_locked", 32'(locked), 0);
    chk("t5_rst_bits", 32'(bit_count), 0);
    do_reset();
    good(12);
    settle();
    chk("t6_locked", 32'(locked4), 1);
    repeat (7) begin bad(3); good(1); end
    settle();
    chk("t6_sat4", 32'(err_count4), 15);
    chk("t6_err16", 32'(err_count), 21);
    nb(b);
    drive(0, 1, ~b, 1);
    settle();
    chk("t6_clr_err4", 32'(err_count4), 1);
    chk("t6_clr_err16", 32'(err_count), 1);
    good(4);
    repeat (3) @(posedge clk);
    #2;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
